elu_arbiter: RTL and testbench



---
 rtl/elu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_elu_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elu_arbiter.sv
// elu_arbiter
// Shares one elu_layer between two requesters with round-robin arbitration.
// The winner's vector is latched on its grant cycle and held on elu_d while
// elu_load is high. The result is captured into q with a one-cycle done pulse.
// elu_load is then held low so that elu_layer clears its indices.
// Optional feature macro: ELU_ARB_TIMEOUT_EN. When it is defined, the arbiter
// abandons a job that runs TIMEOUT cycles without elu_valid, and it raises a
// sticky err output.

`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module elu_arbiter #(
    parameter int DATA_W  = 32*12*`DATA_LEN,
    parameter int LAT_W   = 8
`ifdef ELU_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic [LAT_W-1:0]  last_lat,
    output logic              elu_load,
    output logic [DATA_W-1:0] elu_d,
    input  logic              elu_valid,
    input  logic [DATA_W-1:0] elu_q
`ifdef ELU_ARB_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    // IDLE: arbitrate; RUN: wait for elu_valid; CAPT: take the result;
    // DRAIN: one cycle with load low so elu_layer resets its indices.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CAPT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             rr_ptr;      // requester that wins a tie (0 or 1)
    logic             owner;       // requester holding the current grant
    logic [LAT_W-1:0] lat_cnt;     // cycles since elu_load rose, saturating
    logic             win_any;     // at least one requester is asking
    logic             win_sel;     // index of the requester that would win now
    logic             timeout_hit; // RUN has waited too long for elu_valid

    // Winner selection: a lone requester wins; on a tie the rr pointer decides.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        win_any = req0 | req1;
        win_sel = 1'b0;
        if (req0 && req1) begin
            win_sel = rr_ptr;
        end else begin
            win_sel = req1;
        end
    end

`ifdef ELU_ARB_TIMEOUT_EN
    // Watchdog: the counter is about to reach TIMEOUT and no result has arrived.
    assign timeout_hit = (state == S_RUN) && !elu_valid
                         && (lat_cnt == LAT_W'(TIMEOUT - 1));
`else
    // Without the watchdog, RUN waits for elu_valid indefinitely.
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is written with non-blocking <= so every flop samples the values from before the edge.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (win_any) state_nx = S_RUN;
            S_RUN: begin
                if (elu_valid) begin
                    state_nx = S_CAPT;
                end else if (timeout_hit) begin
                    state_nx = S_DRAIN;
                end
            end
            S_CAPT:  state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Registered handshake, data latch, result capture and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            elu_load <= 1'b0;
            elu_d    <= '0;
            q        <= '0;
            last_lat <= '0;
            lat_cnt  <= '0;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        gnt0     <= ~win_sel;
                        gnt1     <= win_sel;
                        elu_d    <= win_sel ? d1 : d0;
                        elu_load <= 1'b1;
                        lat_cnt  <= '0;
                        rr_ptr   <= ~win_sel;
                        owner    <= win_sel;
                    end
                end
                S_RUN: begin
                    if (!elu_valid) begin
                        if (lat_cnt != '1) begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                        if (timeout_hit) begin
                            gnt0     <= 1'b0;
                            gnt1     <= 1'b0;
                            elu_load <= 1'b0;
                        end
                    end
                end
                S_CAPT: begin
                    q        <= elu_q;
                    last_lat <= lat_cnt;
                    done0    <= ~owner;
                    done1    <= owner;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    elu_load <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ELU_ARB_TIMEOUT_EN
    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_elu_arbiter.sv
// tb_elu_arbiter
// The bench has four parts:
// - A behavioural elu_layer stand-in. Its response delay is programmable.
// - Hand-written corner sequences.
// - A table of arbitration vectors.
// - A randomized run that is scored against a job-level timeline model.
// A narrow vector width keeps the printed values short. The arbiter does not
// depend on the vector width.

`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_elu_arbiter;

    localparam int DW = 8*`DATA_LEN;
    localparam int LW = 8;
    localparam int WL = `DATA_LEN;
    localparam int NW = DW / WL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [DW-1:0] d0 = '0;
    logic [DW-1:0] d1 = '0;
    logic          gnt0, gnt1, done0, done1, busy, elu_load;
    logic [DW-1:0] q, elu_d;
    logic [LW-1:0] last_lat;
    logic          elu_valid = 1'b0;
    logic [DW-1:0] elu_q = '0;
`ifdef ELU_ARB_TIMEOUT_EN
    logic          err;
`endif

    elu_arbiter #(.DATA_W(DW), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .q(q), .busy(busy), .last_lat(last_lat),
        .elu_load(elu_load), .elu_d(elu_d),
        .elu_valid(elu_valid), .elu_q(elu_q)
`ifdef ELU_ARB_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stand-in transform: negative words are halved arithmetically, and other words pass through unchanged.
    function automatic logic [DW-1:0] elu_fn(input logic [DW-1:0] v);
        logic [DW-1:0]        r;
        logic signed [WL-1:0] w;
        r = '0;
        for (int i = 0; i < NW; i++) begin
            w = v[i*WL +: WL];
            r[i*WL +: WL] = (w < 0) ? (w >>> 1) : w;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // elu_layer model: asserts valid elu_delay cycles after load rises, and drops valid while load is low.
    int elu_delay = 5;
    bit elu_stuck = 1'b0;
    int elu_cnt   = 0;
    always @(posedge clk) begin
        if (elu_load !== 1'b1) begin
            elu_cnt   <= 0;
            elu_valid <= 1'b0;
        end else begin
            elu_cnt <= elu_cnt + 1;
            if (!elu_stuck && (elu_cnt + 1 >= elu_delay)) begin
                elu_valid <= 1'b1;
                elu_q     <= elu_fn(elu_d);
            end
        end
    end

    // Counts any cycle in which both grants or both done pulses are high.
    int overlap_cnt = 0;
    always @(negedge clk) begin
        if (rst === 1'b0 && ((gnt0 && gnt1) || (done0 && done1)))
            overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; elu_stuck = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps until the given requester's done is high; waited == budget means it never came.
    task automatic wait_done(input int r, input int budget, output int waited);
        waited = 0;
        while (waited < budget && ((r == 0) ? done0 : done1) !== 1'b1) begin
            step();
            waited++;
        end
    endtask

    typedef struct {
        bit r0;
        bit r1;
        int delay;
        bit g0;
        bit g1;
    } vec_t;

    vec_t          tbl[8];
    int            n, w, bad_d;
    logic [DW-1:0] a_vec, b0, b1, c_vec, v0, v1, wv;

    // Random-phase model state: job timeline arithmetic.
    bit            pend[2];
    int            cool[2];
    int            free_edge, last_served, job_g, job_d, job_w, exp_lat;
    bit            job_valid, eg, e_g0, e_g1, e_d0, e_d1, e_busy;
    logic [DW-1:0] job_data, exp_q;

    initial begin
        // Rows are applied in order from reset; the expected winner follows the tie history.
        tbl[0] = '{1'b1, 1'b1,  5, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1,  1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1,  3, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1,  8, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0,  2, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 12, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1,  4, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1,  6, 1'b1, 1'b0};

        // Reset values.
        do_reset();
        check("reset gnt0", gnt0, 0);
        check("reset gnt1", gnt1, 0);
        check("reset done0", done0, 0);
        check("reset done1", done1, 0);
        check("reset elu_load", elu_load, 0);
        check("reset busy", busy, 0);
        check("reset q", q, 0);
        check("reset elu_d", elu_d, 0);
        check("reset last_lat", last_lat, 0);

        // Single job with a 37-cycle elu, while d0 churns after the grant.
        a_vec = 128'h8000_1234_FFF0_0042_7FFF_C001_0000_ABCD;
        d0 = a_vec; req0 = 1'b1; elu_delay = 37;
        step();
        check("single gnt0", gnt0, 1);
        check("single gnt1", gnt1, 0);
        check("single elu_load", elu_load, 1);
        check("single elu_d", elu_d, a_vec);
        check("single busy", busy, 1);
        n = 0; bad_d = 0;
        while (done0 !== 1'b1 && n < 100) begin
            d0 = rand_vec();
            step();
            n++;
            if (elu_d !== a_vec) bad_d++;
        end
        check("single done0 latency", n, 39);
        check("single elu_d held", bad_d, 0);
        check("single q", q, elu_fn(a_vec));
        check("single last_lat", last_lat, 37);
        check("single drain elu_load", elu_load, 0);
        check("single drain gnt0", gnt0, 0);
        check("single drain busy", busy, 1);
        req0 = 1'b0;
        step();
        check("single done0 one pulse", done0, 0);
        check("single idle busy", busy, 0);

        // Reset ten cycles into RUN, then a fresh job from requester 1.
        d0 = rand_vec(); req0 = 1'b1; elu_delay = 100;
        step();
        check("midrst gnt0", gnt0, 1);
        repeat (10) step();
        rst = 1'b1; req0 = 1'b0;
        step();
        check("midrst gnt0 cleared", gnt0, 0);
        check("midrst gnt1", gnt1, 0);
        check("midrst done0", done0, 0);
        check("midrst done1", done1, 0);
        check("midrst elu_load", elu_load, 0);
        check("midrst busy", busy, 0);
        check("midrst q", q, 0);
        check("midrst elu_d", elu_d, 0);
        check("midrst last_lat", last_lat, 0);
        rst = 1'b0;
        c_vec = rand_vec(); d1 = c_vec; req1 = 1'b1; elu_delay = 6;
        step();
        check("midrst new gnt1", gnt1, 1);
        check("midrst new gnt0", gnt0, 0);
        wait_done(1, 50, n);
        check("midrst done1 latency", n, 8);
        check("midrst q", q, elu_fn(c_vec));
        check("midrst last_lat", last_lat, 6);
        req1 = 1'b0;
        step();

        // Latency counter saturation.
        d0 = rand_vec(); req0 = 1'b1; elu_delay = 300;
        step();
        wait_done(0, 400, n);
        check("sat done0 latency", n, 302);
        check("sat last_lat", last_lat, 255);
        req0 = 1'b0;
        step();

        // Tie right after reset: requester 0 first, requester 1 granted two cycles after done0.
        do_reset();
        b0 = rand_vec(); b1 = rand_vec();
        d0 = b0; d1 = b1; req0 = 1'b1; req1 = 1'b1; elu_delay = 4;
        step();
        check("tie gnt0", gnt0, 1);
        check("tie gnt1 waits", gnt1, 0);
        check("tie elu_d", elu_d, b0);
        wait_done(0, 50, n);
        check("tie done0 latency", n, 6);
        req0 = 1'b0;
        step();
        check("tie gnt1 after 1", gnt1, 0);
        step();
        check("tie gnt1 after 2", gnt1, 1);
        check("tie elu_d second", elu_d, b1);
        d1 = rand_vec();
        wait_done(1, 50, n);
        check("tie done1 latency", n, 6);
        check("tie q", q, elu_fn(b1));
        req1 = 1'b0;
        step();

        // Fairness: both requesters re-request right after each done.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; elu_delay = 3;
        for (int j = 0; j < 4; j++) begin
            step();
            w = j % 2;
            check($sformatf("fair%0d gnt0", j), gnt0, (w == 0));
            check($sformatf("fair%0d gnt1", j), gnt1, (w == 1));
            wait_done(w, 50, n);
            check($sformatf("fair%0d latency", j), n, 5);
            if (w == 0) req0 = 1'b0; else req1 = 1'b0;
            step();
            if (w == 0) req0 = 1'b1; else req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Table-driven arbitration vectors.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v0 = rand_vec(); v1 = rand_vec();
            d0 = v0; d1 = v1;
            req0 = tbl[i].r0; req1 = tbl[i].r1; elu_delay = tbl[i].delay;
            step();
            check($sformatf("tbl%0d gnt0", i), gnt0, tbl[i].g0);
            check($sformatf("tbl%0d gnt1", i), gnt1, tbl[i].g1);
            w  = tbl[i].g1 ? 1 : 0;
            wv = tbl[i].g1 ? v1 : v0;
            check($sformatf("tbl%0d elu_d", i), elu_d, wv);
            wait_done(w, 60, n);
            check($sformatf("tbl%0d latency", i), n, tbl[i].delay + 2);
            check($sformatf("tbl%0d q", i), q, elu_fn(wv));
            check($sformatf("tbl%0d last_lat", i), last_lat, tbl[i].delay);
            req0 = 1'b0; req1 = 1'b0;
            step();
        end

        // Randomized traffic against the job timeline model.
        // A job granted at cycle g with elu delay D has gnt/load high for cycles g..g+D+1 and done at g+D+2.
        // It keeps busy high through g+D+2, and the next grant is possible no earlier than cycle g+D+4.
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0; cool[0] = 0; cool[1] = 0;
        free_edge = 1; last_served = 1; job_valid = 1'b0;
        job_g = 0; job_d = 0; job_w = 0; exp_lat = 0; exp_q = '0; job_data = '0;
        for (int t = 0; t < 1500; t++) begin
            e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0; e_busy = 1'b0; eg = 1'b0;
            if (job_valid) begin
                eg = (t >= job_g) && (t <= job_g + job_d + 1);
                if (job_w == 0) e_g0 = eg; else e_g1 = eg;
                if (t == job_g + job_d + 2) begin
                    if (job_w == 0) e_d0 = 1'b1; else e_d1 = 1'b1;
                    exp_q   = elu_fn(job_data);
                    exp_lat = (job_d > 255) ? 255 : job_d;
                end
                e_busy = (t >= job_g) && (t <= job_g + job_d + 2);
                if (eg) check("rand elu_d", elu_d, job_data);
            end
            check("rand gnt0", gnt0, e_g0);
            check("rand gnt1", gnt1, e_g1);
            check("rand done0", done0, e_d0);
            check("rand done1", done1, e_d1);
            check("rand elu_load", elu_load, eg);
            check("rand busy", busy, e_busy);
            check("rand q", q, exp_q);
            check("rand last_lat", last_lat, exp_lat);

            for (int r = 0; r < 2; r++) begin
                if (job_valid && job_w == r && t == job_g + job_d + 2) begin
                    pend[r] = 1'b0;
                    cool[r] = t + 1;
                end else if (!pend[r] && t >= cool[r] && $urandom_range(0, 3) == 0) begin
                    pend[r] = 1'b1;
                end
            end
            d0 = rand_vec();
            d1 = rand_vec();
            if (t + 1 >= free_edge && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = 1 - last_served;
                else                    w = pend[1] ? 1 : 0;
                job_valid   = 1'b1;
                job_w       = w;
                job_g       = t + 1;
                job_d       = $urandom_range(1, 12);
                job_data    = (w == 1) ? d1 : d0;
                last_served = w;
                elu_delay   = job_d;
                free_edge   = t + 1 + job_d + 4;
            end
            req0 = pend[0];
            req1 = pend[1];
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (20) step();

`ifdef ELU_ARB_TIMEOUT_EN
        // Watchdog: elu never answers, the job is abandoned after 64 RUN cycles, and err stays sticky.
        do_reset();
        check("to err reset", err, 0);
        elu_stuck = 1'b1; d0 = rand_vec(); req0 = 1'b1;
        step();
        check("to gnt0", gnt0, 1);
        n = 0;
        while (elu_load === 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("to run cycles", n, 64);
        check("to err set", err, 1);
        check("to no done0", done0, 0);
        check("to gnt0 dropped", gnt0, 0);
        check("to q unchanged", q, 0);
        req0 = 1'b0; elu_stuck = 1'b0;
        step();
        check("to err sticky", err, 1);
        check("to no done0 later", done0, 0);
        check("to idle busy", busy, 0);
        v1 = rand_vec(); d1 = v1; req1 = 1'b1; elu_delay = 3;
        step();
        check("to next gnt1", gnt1, 1);
        wait_done(1, 50, n);
        check("to next latency", n, 5);
        check("to next q", q, elu_fn(v1));
        check("to err still set", err, 1);
        req1 = 1'b0;
        step();
`endif

        check("gnt/done overlap cycles", overlap_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
